// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM macro among NUM_REQ word-request
// ports: same-cycle grant, 1-cycle read return, per-requester lock for bursts.
module sram_rr_arbiter #(
  parameter  int NUM_REQ         = 4,
  parameter  int DATA_WIDTH      = 32,
  parameter  int SRAM_WORD_DEPTH = 512,
  localparam int ADDR_WIDTH      = $clog2(SRAM_WORD_DEPTH),
  localparam int STRB_WIDTH      = DATA_WIDTH / 8,
  localparam int IDX_WIDTH       = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ-1:0]            lock_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_REQ*STRB_WIDTH-1:0] wstrb_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          sram_en_o,
  output logic                          sram_we_o,
  output logic [ADDR_WIDTH-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0]         sram_wdata_o,
  output logic [STRB_WIDTH-1:0]         sram_wstrb_o,
  input  logic [DATA_WIDTH-1:0]         sram_rdata_i
);

  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0] lock_idx_q, lock_idx_d;
  logic                 lock_vld_q, lock_vld_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;

  logic                 win_vld;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 lo_vld, hi_vld;
  logic [IDX_WIDTH-1:0] lo_idx, hi_idx;

  // Lowest requester at/above ptr wins; otherwise wrap to the lowest below ptr.
  // A locked owner that drops req releases immediately, so RR runs the same cycle.
  always_comb begin
    lo_vld  = 1'b0;
    lo_idx  = '0;
    hi_vld  = 1'b0;
    hi_idx  = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i] && (IDX_WIDTH'(i) < ptr_q)) begin
        lo_vld = 1'b1;
        lo_idx = IDX_WIDTH'(i);
      end
      if (req_i[i] && (IDX_WIDTH'(i) >= ptr_q)) begin
        hi_vld = 1'b1;
        hi_idx = IDX_WIDTH'(i);
      end
    end
    if (lock_vld_q && req_i[lock_idx_q]) begin
      win_vld = 1'b1;
      win_idx = lock_idx_q;
    end else if (hi_vld) begin
      win_vld = 1'b1;
      win_idx = hi_idx;
    end else if (lo_vld) begin
      win_vld = 1'b1;
      win_idx = lo_idx;
    end
    if (rst_i) begin
      win_vld = 1'b0;
    end
  end

  assign gnt_o        = win_vld ? (NUM_REQ'(1) << win_idx) : '0;
  assign sram_en_o    = win_vld;
  assign sram_we_o    = win_vld & we_i[win_idx];
  assign sram_addr_o  = win_vld ? addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign sram_wdata_o = win_vld ? wdata_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign sram_wstrb_o = win_vld ? wstrb_i[int'(win_idx)*STRB_WIDTH +: STRB_WIDTH] : '0;

  always_comb begin
    ptr_d      = ptr_q;
    lock_vld_d = 1'b0;
    lock_idx_d = lock_idx_q;
    rvalid_d   = gnt_o & ~we_i;
    if (win_vld) begin
      ptr_d = (win_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      if (lock_i[win_idx]) begin
        lock_vld_d = 1'b1;
        lock_idx_d = win_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      rvalid_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // A read whose return cycle coincides with reset is dropped.
  assign rvalid_o = rst_i ? '0 : rvalid_q;
  assign rdata_o  = sram_rdata_i;

  a_gnt_onehot: assert property (@(posedge clk_i) $onehot0(gnt_o));
  a_rvalid_onehot: assert property (@(posedge clk_i) $onehot0(rvalid_o));

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chk
      a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (req_i[gi] && !gnt_o[gi]) |=> (req_i[gi] && $stable(we_i[gi]) && $stable(lock_i[gi])
          && $stable(addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH])
          && $stable(wdata_i[gi*DATA_WIDTH +: DATA_WIDTH])
          && $stable(wstrb_i[gi*STRB_WIDTH +: STRB_WIDTH])));
      a_rvalid_read: assert property (@(posedge clk_i) disable iff (rst_i)
        rvalid_o[gi] |-> $past(gnt_o[gi] && !we_i[gi]));
    end
  endgenerate

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Scoreboard bench for sram_rr_arbiter: per-requester op queues drive the DUT, a
// spec-level model predicts grants and read data, a monitor checks read returns.
module tb_sram_rr_arbiter;
  localparam int N = 4, DW = 32, DEPTH = 512, AW = $clog2(DEPTH), SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0, we = '0, lock = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N*SW-1:0] wstrb = '0;
  logic [N-1:0] gnt, rvalid;
  logic [DW-1:0] rdata;
  logic sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [SW-1:0] sram_wstrb;

  always #5 clk = ~clk;

  sram_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .SRAM_WORD_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .lock_i(lock),
    .addr_i(addr), .wdata_i(wdata), .wstrb_i(wstrb),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_wstrb_o(sram_wstrb), .sram_rdata_i(sram_rdata)
  );

  // SRAM macro behaviour, driven only by the DUT's macro-side outputs.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < SW; b++)
          if (sram_wstrb[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          lock;
  } op_t;

  typedef struct packed {
    logic [31:0]   due;
    logic [7:0]    idx;
    logic [DW-1:0] data;
  } rd_t;

  op_t opq [N][$];
  rd_t sbq [$];
  bit present [N];
  bit rand_gaps = 1'b0;
  logic [DW-1:0] ref_mem [DEPTH];
  int unsigned cyc = 0;
  int tests = 0, fails = 0;
  int ptr_m = 0, li_m = 0;
  bit lv_m = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int k, input bit w, input int a, input logic [31:0] d,
                      input logic [3:0] s, input bit l);
    op_t o;
    o.we = w; o.addr = AW'(a); o.wdata = d; o.wstrb = s; o.lock = l;
    opq[k].push_back(o);
  endtask

  function automatic bit busy();
    bit b = 1'b0;
    for (int k = 0; k < N; k++) if (present[k] || opq[k].size() > 0) b = 1'b1;
    return b;
  endfunction

  // One clock cycle: drive inputs, predict the grant from arbitration rules, check.
  task automatic cycle(input bit r);
    int win;
    op_t o;
    logic [N-1:0] exp_gnt;
    @(negedge clk);
    cyc++;
    rst = r;
    for (int k = 0; k < N; k++) begin
      if (!present[k] && opq[k].size() > 0 && (!rand_gaps || $urandom_range(3) != 0))
        present[k] = 1'b1;
      req[k] = present[k];
      if (present[k]) begin
        o = opq[k][0];
        we[k] = o.we; lock[k] = o.lock;
        addr[k*AW +: AW] = o.addr; wdata[k*DW +: DW] = o.wdata; wstrb[k*SW +: SW] = o.wstrb;
      end else begin
        we[k] = 1'($urandom); lock[k] = 1'($urandom);
        addr[k*AW +: AW] = AW'($urandom); wdata[k*DW +: DW] = $urandom;
        wstrb[k*SW +: SW] = SW'($urandom);
      end
    end
    if (r) begin
      sbq.delete();
      ptr_m = 0; lv_m = 1'b0; li_m = 0;
    end
    #1;
    win = -1;
    if (!r) begin
      if (lv_m && req[li_m]) win = li_m;
      else
        for (int i = 0; i < N; i++)
          if (win < 0 && req[(ptr_m + i) % N]) win = (ptr_m + i) % N;
    end
    exp_gnt = (win >= 0) ? (N'(1) << win) : '0;
    check("gnt", 64'(gnt), 64'(exp_gnt));
    check("sram_en", 64'(sram_en), 64'(win >= 0));
    if (win >= 0) begin
      o = opq[win].pop_front();
      present[win] = 1'b0;
      check("sram_we", 64'(sram_we), 64'(o.we));
      check("sram_addr", 64'(sram_addr), 64'(o.addr));
      if (o.we) begin
        check("sram_wdata", 64'(sram_wdata), 64'(o.wdata));
        check("sram_wstrb", 64'(sram_wstrb), 64'(o.wstrb));
        for (int b = 0; b < SW; b++)
          if (o.wstrb[b]) ref_mem[o.addr][8*b +: 8] = o.wdata[8*b +: 8];
      end else begin
        sbq.push_back('{due: cyc + 1, idx: 8'(win), data: ref_mem[o.addr]});
      end
      $display("[TB] cyc %0d grant req%0d %s addr 0x%03h lock %0d", cyc, win,
               o.we ? "WR" : "RD", o.addr, o.lock);
      ptr_m = (win + 1) % N;
      lv_m = o.lock;
      li_m = win;
    end else begin
      check("sram_addr_idle", 64'(sram_addr), 64'd0);
      check("sram_wstrb_idle", 64'(sram_wstrb), 64'd0);
      if (!r) lv_m = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int left = budget;
    while (busy() && left > 0) begin
      cycle(1'b0);
      left--;
    end
    check("drain_timeout", 64'(busy()), 64'd0);
    repeat (2) cycle(1'b0);
  endtask

  // Monitor: every cycle, either the due read returns or rvalid must stay low.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        check("rvalid", 64'(rvalid), 64'(N'(1) << sbq[0].idx));
        check("rdata", 64'(rdata), 64'(sbq[0].data));
        void'(sbq.pop_front());
      end else begin
        check("rvalid_idle", 64'(rvalid), 64'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    // Reset held with everyone requesting; first grant afterwards is requester 0.
    for (int k = 0; k < N; k++) push(k, 1'b0, k, 0, 4'h0, 1'b0);
    repeat (5) cycle(1'b1);
    drain(50);
    // Single write then read.
    push(0, 1'b1, 'h010, 32'hDEADBEEF, 4'hF, 1'b0);
    push(0, 1'b0, 'h010, 0, 4'h0, 1'b0);
    drain(50);
    // Fairness: all four reading continuously from ptr 0.
    cycle(1'b1);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) push(k, 1'b0, 'h010 + k, 0, 4'h0, 1'b0);
    drain(50);
    // Byte strobes, including a zero-strobe write.
    push(2, 1'b1, 5, 32'h11223344, 4'hF, 1'b0);
    push(2, 1'b1, 5, 32'hAABBCCDD, 4'h2, 1'b0);
    push(2, 1'b1, 5, 32'h55555555, 4'h0, 1'b0);
    push(2, 1'b0, 5, 0, 4'h0, 1'b0);
    drain(50);
    // Lock burst, then a burst whose owner drops req while still locked.
    push(1, 1'b1, 'h20, 32'h1, 4'hF, 1'b1);
    push(1, 1'b1, 'h21, 32'h2, 4'hF, 1'b1);
    push(1, 1'b1, 'h22, 32'h3, 4'hF, 1'b1);
    push(1, 1'b1, 'h23, 32'h4, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) push(2, 1'b1, 'h30 + i, 32'h100 + i, 4'hF, 1'b0);
    drain(50);
    push(1, 1'b1, 'h24, 32'h5, 4'hF, 1'b1);
    push(1, 1'b1, 'h25, 32'h6, 4'hF, 1'b1);
    for (int i = 0; i < 3; i++) push(2, 1'b0, 'h20 + i, 0, 4'h0, 1'b0);
    drain(50);
    // Reset in the cycle after a read grant; pointer must restart at 0.
    push(1, 1'b0, 'h20, 0, 4'h0, 1'b0);
    cycle(1'b0);
    cycle(1'b1);
    push(2, 1'b0, 'h21, 0, 4'h0, 1'b0);
    push(0, 1'b0, 'h22, 0, 4'h0, 1'b0);
    drain(50);
    // Randomized traffic with idle gaps and random locks.
    rand_gaps = 1'b1;
    for (int i = 0; i < 400; i++)
      push($urandom_range(N - 1), 1'($urandom), $urandom_range(15), $urandom,
           4'($urandom), $urandom_range(3) == 0);
    drain(4000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
